// File: rtl/ocp_fabric2.sv
// Two-master / five-slave OCP crossbar with per-slave-port round-robin arbitration.
// Command and response paths are combinational; unmapped accesses answer ERR one cycle later.
module ocp_fabric2 #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_I_MAddr,
  input  logic [2:0]            i_I_MCmd,
  input  logic [DATA_WIDTH-1:0] i_I_MData,
  input  logic [BEN_WIDTH-1:0]  i_I_MByteEn,
  output logic                  o_I_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_I_SData,
  output logic [1:0]            o_I_SResp,
  input  logic [ADDR_WIDTH-1:0] i_D_MAddr,
  input  logic [2:0]            i_D_MCmd,
  input  logic [DATA_WIDTH-1:0] i_D_MData,
  input  logic [BEN_WIDTH-1:0]  i_D_MByteEn,
  output logic                  o_D_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_D_SData,
  output logic [1:0]            o_D_SResp,
  output logic [ADDR_WIDTH-1:0] o_P0_MAddr,
  output logic [2:0]            o_P0_MCmd,
  output logic [DATA_WIDTH-1:0] o_P0_MData,
  output logic [BEN_WIDTH-1:0]  o_P0_MByteEn,
  input  logic                  i_P0_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P0_SData,
  input  logic [1:0]            i_P0_SResp,
  output logic [ADDR_WIDTH-1:0] o_P1_MAddr,
  output logic [2:0]            o_P1_MCmd,
  output logic [DATA_WIDTH-1:0] o_P1_MData,
  output logic [BEN_WIDTH-1:0]  o_P1_MByteEn,
  input  logic                  i_P1_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P1_SData,
  input  logic [1:0]            i_P1_SResp,
  output logic [ADDR_WIDTH-1:0] o_P2_MAddr,
  output logic [2:0]            o_P2_MCmd,
  output logic [DATA_WIDTH-1:0] o_P2_MData,
  output logic [BEN_WIDTH-1:0]  o_P2_MByteEn,
  input  logic                  i_P2_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P2_SData,
  input  logic [1:0]            i_P2_SResp,
  output logic [ADDR_WIDTH-1:0] o_P3_MAddr,
  output logic [2:0]            o_P3_MCmd,
  output logic [DATA_WIDTH-1:0] o_P3_MData,
  output logic [BEN_WIDTH-1:0]  o_P3_MByteEn,
  input  logic                  i_P3_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P3_SData,
  input  logic [1:0]            i_P3_SResp,
  output logic [ADDR_WIDTH-1:0] o_P4_MAddr,
  output logic [2:0]            o_P4_MCmd,
  output logic [DATA_WIDTH-1:0] o_P4_MData,
  output logic [BEN_WIDTH-1:0]  o_P4_MByteEn,
  input  logic                  i_P4_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P4_SData,
  input  logic [1:0]            i_P4_SResp
);
  localparam int unsigned NM = 2;
  localparam int unsigned NP = 5;
  localparam int unsigned CW = 3;
  localparam int unsigned RW = 2;
  localparam int unsigned PW = 3;
  localparam logic [CW-1:0] CMD_IDLE  = CW'(0);
  localparam logic [CW-1:0] CMD_WR    = CW'(1);
  localparam logic [CW-1:0] CMD_RD    = CW'(2);
  localparam logic [RW-1:0] RESP_NULL = RW'(0);
  localparam logic [RW-1:0] RESP_ERR  = RW'(3);
  localparam logic [PW-1:0] PORT_NONE = PW'(5);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  logic [ADDR_WIDTH-1:0] m_addr [NM];
  logic [CW-1:0]         m_cmd  [NM];
  logic [DATA_WIDTH-1:0] m_data [NM];
  logic [BEN_WIDTH-1:0]  m_ben  [NM];
  logic                  m_acc  [NM];
  logic [DATA_WIDTH-1:0] m_sdata[NM];
  logic [RW-1:0]         m_sresp[NM];
  logic                  req    [NM];
  logic [PW-1:0]         dec    [NM];
  logic                  err_q  [NM];
  logic                  err_d  [NM];

  logic [ADDR_WIDTH-1:0] p_addr [NP];
  logic [CW-1:0]         p_cmd  [NP];
  logic [DATA_WIDTH-1:0] p_data [NP];
  logic [BEN_WIDTH-1:0]  p_ben  [NP];
  logic                  s_acc  [NP];
  logic [DATA_WIDTH-1:0] s_data [NP];
  logic [RW-1:0]         s_resp [NP];

  state_t state_q[NP], state_d[NP];
  logic   owner_q[NP], owner_d[NP];
  logic   last_q [NP], last_d [NP];
  logic   rq_i, rq_d, gnt;

  // Port map: addr[31]=0 is memory, 0x800..0x803 in the top 12 bits are the peripherals.
  function automatic logic [PW-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [11:0]   top;
    logic [PW-1:0] res;
    top = a[ADDR_WIDTH-1 -: 12];
    res = PORT_NONE;
    if (!a[ADDR_WIDTH-1]) res = PW'(0);
    else begin
      case (top)
        12'h800: res = PW'(1);
        12'h801: res = PW'(2);
        12'h802: res = PW'(3);
        12'h803: res = PW'(4);
        default: res = PORT_NONE;
      endcase
    end
    return res;
  endfunction

  assign m_addr[0] = i_I_MAddr;  assign m_cmd[0] = i_I_MCmd;
  assign m_data[0] = i_I_MData;  assign m_ben[0] = i_I_MByteEn;
  assign m_addr[1] = i_D_MAddr;  assign m_cmd[1] = i_D_MCmd;
  assign m_data[1] = i_D_MData;  assign m_ben[1] = i_D_MByteEn;

  assign s_acc[0] = i_P0_SCmdAccept; assign s_data[0] = i_P0_SData; assign s_resp[0] = i_P0_SResp;
  assign s_acc[1] = i_P1_SCmdAccept; assign s_data[1] = i_P1_SData; assign s_resp[1] = i_P1_SResp;
  assign s_acc[2] = i_P2_SCmdAccept; assign s_data[2] = i_P2_SData; assign s_resp[2] = i_P2_SResp;
  assign s_acc[3] = i_P3_SCmdAccept; assign s_data[3] = i_P3_SData; assign s_resp[3] = i_P3_SResp;
  assign s_acc[4] = i_P4_SCmdAccept; assign s_data[4] = i_P4_SData; assign s_resp[4] = i_P4_SResp;

  // Arbitration, routing and response steering; everything is forced quiet during reset.
  always_comb begin
    rq_i = 1'b0;
    rq_d = 1'b0;
    gnt  = 1'b0;
    for (int unsigned n = 0; n < NP; n++) begin
      state_d[n] = state_q[n];
      owner_d[n] = owner_q[n];
      last_d[n]  = last_q[n];
      p_addr[n]  = '0;
      p_cmd[n]   = CMD_IDLE;
      p_data[n]  = '0;
      p_ben[n]   = '0;
    end
    for (int unsigned m = 0; m < NM; m++) begin
      m_acc[m]   = 1'b0;
      m_sdata[m] = '0;
      m_sresp[m] = RESP_NULL;
      err_d[m]   = 1'b0;
      req[m]     = (m_cmd[m] == CMD_WR) || (m_cmd[m] == CMD_RD);
      dec[m]     = decode(m_addr[m]);
    end
    if (!nrst) begin
      for (int unsigned n = 0; n < NP; n++) begin
        rq_i = req[0] && (dec[0] == PW'(n));
        rq_d = req[1] && (dec[1] == PW'(n));
        gnt  = (rq_i && rq_d) ? ~last_q[n] : rq_d;
        if (state_q[n] == ST_IDLE) begin
          if (rq_i || rq_d) begin
            p_addr[n]  = m_addr[gnt];
            p_cmd[n]   = m_cmd[gnt];
            p_data[n]  = m_data[gnt];
            p_ben[n]   = m_ben[gnt];
            m_acc[gnt] = s_acc[n];
            if (s_acc[n]) begin
              state_d[n] = ST_BUSY;
              owner_d[n] = gnt;
              last_d[n]  = gnt;
            end
          end
        end else begin
          m_sdata[owner_q[n]] = s_data[n];
          m_sresp[owner_q[n]] = s_resp[n];
          if (s_resp[n] != RESP_NULL) state_d[n] = ST_IDLE;
        end
      end
      for (int unsigned m = 0; m < NM; m++) begin
        if (req[m] && (dec[m] == PORT_NONE)) begin
          m_acc[m] = 1'b1;
          err_d[m] = 1'b1;
        end
        if (err_q[m]) begin
          m_sresp[m] = RESP_ERR;
          m_sdata[m] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int unsigned n = 0; n < NP; n++) begin
        state_q[n] <= ST_IDLE;
        owner_q[n] <= 1'b0;
        last_q[n]  <= 1'b0;
      end
      for (int unsigned m = 0; m < NM; m++) err_q[m] <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < NP; n++) begin
        state_q[n] <= state_d[n];
        owner_q[n] <= owner_d[n];
        last_q[n]  <= last_d[n];
      end
      for (int unsigned m = 0; m < NM; m++) err_q[m] <= err_d[m];
    end
  end

  assign o_I_SCmdAccept = m_acc[0]; assign o_I_SData = m_sdata[0]; assign o_I_SResp = m_sresp[0];
  assign o_D_SCmdAccept = m_acc[1]; assign o_D_SData = m_sdata[1]; assign o_D_SResp = m_sresp[1];

  assign o_P0_MAddr = p_addr[0]; assign o_P0_MCmd = p_cmd[0];
  assign o_P0_MData = p_data[0]; assign o_P0_MByteEn = p_ben[0];
  assign o_P1_MAddr = p_addr[1]; assign o_P1_MCmd = p_cmd[1];
  assign o_P1_MData = p_data[1]; assign o_P1_MByteEn = p_ben[1];
  assign o_P2_MAddr = p_addr[2]; assign o_P2_MCmd = p_cmd[2];
  assign o_P2_MData = p_data[2]; assign o_P2_MByteEn = p_ben[2];
  assign o_P3_MAddr = p_addr[3]; assign o_P3_MCmd = p_cmd[3];
  assign o_P3_MData = p_data[3]; assign o_P3_MByteEn = p_ben[3];
  assign o_P4_MAddr = p_addr[4]; assign o_P4_MCmd = p_cmd[4];
  assign o_P4_MData = p_data[4]; assign o_P4_MByteEn = p_ben[4];
endmodule

// File: tb/tb_ocp_fabric2.sv
// Bench for ocp_fabric2: combinational routing table, directed arbitration/ERR/reset
// sequences, then random traffic from both masters against memory-like slave models.
`timescale 1ns/1ps
module tb_ocp_fabric2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] maddr [2];
  logic [2:0]    mcmd  [2];
  logic [DW-1:0] mdata [2];
  logic [BW-1:0] mben  [2];
  logic          macc  [2];
  logic [DW-1:0] msdata[2];
  logic [1:0]    msresp[2];

  logic [AW-1:0] paddr [5];
  logic [2:0]    pcmd  [5];
  logic [DW-1:0] pdata [5];
  logic [BW-1:0] pben  [5];
  logic          sacc  [5];
  logic [DW-1:0] sdata [5];
  logic [1:0]    sresp [5];

  int errors = 0;
  int checks = 0;

  ocp_fabric2 dut (
    .clk(clk), .nrst(nrst),
    .i_I_MAddr(maddr[0]), .i_I_MCmd(mcmd[0]), .i_I_MData(mdata[0]), .i_I_MByteEn(mben[0]),
    .o_I_SCmdAccept(macc[0]), .o_I_SData(msdata[0]), .o_I_SResp(msresp[0]),
    .i_D_MAddr(maddr[1]), .i_D_MCmd(mcmd[1]), .i_D_MData(mdata[1]), .i_D_MByteEn(mben[1]),
    .o_D_SCmdAccept(macc[1]), .o_D_SData(msdata[1]), .o_D_SResp(msresp[1]),
    .o_P0_MAddr(paddr[0]), .o_P0_MCmd(pcmd[0]), .o_P0_MData(pdata[0]), .o_P0_MByteEn(pben[0]),
    .i_P0_SCmdAccept(sacc[0]), .i_P0_SData(sdata[0]), .i_P0_SResp(sresp[0]),
    .o_P1_MAddr(paddr[1]), .o_P1_MCmd(pcmd[1]), .o_P1_MData(pdata[1]), .o_P1_MByteEn(pben[1]),
    .i_P1_SCmdAccept(sacc[1]), .i_P1_SData(sdata[1]), .i_P1_SResp(sresp[1]),
    .o_P2_MAddr(paddr[2]), .o_P2_MCmd(pcmd[2]), .o_P2_MData(pdata[2]), .o_P2_MByteEn(pben[2]),
    .i_P2_SCmdAccept(sacc[2]), .i_P2_SData(sdata[2]), .i_P2_SResp(sresp[2]),
    .o_P3_MAddr(paddr[3]), .o_P3_MCmd(pcmd[3]), .o_P3_MData(pdata[3]), .o_P3_MByteEn(pben[3]),
    .i_P3_SCmdAccept(sacc[3]), .i_P3_SData(sdata[3]), .i_P3_SResp(sresp[3]),
    .o_P4_MAddr(paddr[4]), .o_P4_MCmd(pcmd[4]), .o_P4_MData(pdata[4]), .o_P4_MByteEn(pben[4]),
    .i_P4_SCmdAccept(sacc[4]), .i_P4_SData(sdata[4]), .i_P4_SResp(sresp[4])
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave models: accept when idle (optionally randomly), answer DVA after lat_min..lat_max cycles.
  logic          man_mode = 1'b1;
  logic [4:0]    man_acc  = '0;
  logic          rnd_acc  = 1'b0;
  int unsigned   lat_min  = 0;
  int unsigned   lat_max  = 2;
  logic          pend  [5] = '{default: 1'b0};
  int unsigned   cnt   [5] = '{default: 0};
  logic          prd   [5] = '{default: 1'b0};
  logic [DW-1:0] prdata[5] = '{default: '0};
  logic          acc_en[5] = '{default: 1'b1};
  logic [DW-1:0] smem [logic [AW-1:0]];

  always_comb begin
    for (int n = 0; n < 5; n++) begin
      sacc[n]  = man_mode ? man_acc[n] : (!pend[n] && acc_en[n]);
      sresp[n] = (!man_mode && pend[n] && cnt[n] == 0) ? 2'd1 : 2'd0;
      sdata[n] = (sresp[n] == 2'd1 && prd[n]) ? prdata[n] : '0;
    end
  end

  always @(posedge clk) begin
    for (int n = 0; n < 5; n++) begin
      acc_en[n] <= rnd_acc ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!man_mode) begin
        if (pend[n]) begin
          if (cnt[n] == 0) pend[n] <= 1'b0;
          else cnt[n] <= cnt[n] - 1;
        end else if (pcmd[n] != 3'd0 && sacc[n]) begin
          pend[n]   <= 1'b1;
          cnt[n]    <= $urandom_range(lat_min, lat_max);
          prd[n]    <= (pcmd[n] == 3'd2);
          prdata[n] <= smem.exists(paddr[n]) ? smem[paddr[n]] : '0;
          if (pcmd[n] == 3'd1) smem[paddr[n]] = pdata[n];
        end
      end
    end
  end

  // Address map as stated for the fabric: 5 means unmapped.
  function automatic int unsigned tb_port(input logic [31:0] a);
    logic [11:0] t;
    t = a[31:20];
    if (!a[31]) return 0;
    case (t)
      12'h800: return 1;
      12'h801: return 2;
      12'h802: return 3;
      12'h803: return 4;
      default: return 5;
    endcase
  endfunction

  // Routing/round-robin monitor for the random phase, reasoning per slave port.
  logic       mon_en = 1'b0;
  logic       last_tb[5] = '{default: 1'b0};
  logic       mrq0, mrq1, mw, mv;
  logic [70:0] mexp;
  always @(negedge clk) begin
    if (nrst) begin
      for (int n = 0; n < 5; n++) last_tb[n] = 1'b0;
    end else if (mon_en) begin
      for (int n = 0; n < 5; n++) begin
        mrq0 = (mcmd[0] == 3'd1 || mcmd[0] == 3'd2) && tb_port(maddr[0]) == n;
        mrq1 = (mcmd[1] == 3'd1 || mcmd[1] == 3'd2) && tb_port(maddr[1]) == n;
        mv   = !pend[n] && (mrq0 || mrq1);
        mw   = (mrq0 && mrq1) ? !last_tb[n] : mrq1;
        mexp = mv ? {mcmd[mw], maddr[mw], mdata[mw], mben[mw]} : '0;
        chk($sformatf("mon_port%0d", n), 128'({pcmd[n], paddr[n], pdata[n], pben[n]}), 128'(mexp));
        if (mv && sacc[n]) last_tb[n] = mw;
      end
    end
  end

  task automatic do_txn(input int m, input logic [2:0] cmd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [1:0] resp,
                        output logic [DW-1:0] rd, output int cyc);
    bit got;
    maddr[m] = a; mcmd[m] = cmd; mdata[m] = d; mben[m] = 4'hF;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = macc[m];
      @(posedge clk); #1;
    end
    maddr[m] = '0; mcmd[m] = 3'd0; mdata[m] = '0; mben[m] = '0;
    resp = 2'd0; rd = '0; cyc = -1;
    if (!got) begin
      chk($sformatf("accept_timeout_m%0d", m), 128'(0), 128'(1));
      return;
    end
    for (int k = 1; k <= 200 && resp == 2'd0; k++) begin
      @(negedge clk);
      if (msresp[m] != 2'd0) begin
        resp = msresp[m]; rd = msdata[m]; cyc = k;
      end
      @(posedge clk); #1;
    end
    if (resp == 2'd0) chk($sformatf("resp_timeout_m%0d", m), 128'(0), 128'(1));
  endtask

  task automatic conflict(input string nm, input bit d_first);
    logic [1:0] ri, rd;
    logic [DW-1:0] di, dd;
    int ci, cd;
    time ti, td;
    ti = 0; td = 0;
    fork
      begin do_txn(0, 3'd2, 32'h4, '0, ri, di, ci); ti = $time; end
      begin do_txn(1, 3'd2, 32'h8, '0, rd, dd, cd); td = $time; end
    join
    chk({nm, "_I_data"}, 128'(di), 128'(32'hF1F2F3F4));
    chk({nm, "_D_data"}, 128'(dd), 128'(32'hF5F6F7F8));
    chk({nm, "_order"}, 128'(d_first ? (td < ti) : (ti < td)), 128'(1));
  endtask

  logic [AW-1:0] ref_mem [logic [AW-1:0]];
  logic [31:0]   bases [8] = '{32'h0000_0000, 32'h8000_0000, 32'h8010_0000, 32'h8020_0000,
                               32'h8030_0000, 32'h9000_0000, 32'h8040_0000, 32'hFFF0_0000};

  task automatic master_run(input int m, input int n_txn);
    logic [1:0] r; logic [DW-1:0] d, rdv, expd; int c; int unsigned sel;
    logic [AW-1:0] a; logic [2:0] cmd;
    for (int k = 0; k < n_txn; k++) begin
      sel = $urandom_range(0, 7);
      a   = bases[sel] + 32'h400 + 32'($urandom_range(0, 7) * 8) + 32'(m * 4);
      cmd = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd2;
      d   = $urandom;
      expd = (cmd == 3'd2 && ref_mem.exists(a)) ? ref_mem[a] : '0;
      do_txn(m, cmd, a, d, r, rdv, c);
      if (sel >= 5) begin
        chk($sformatf("rnd_err_resp m%0d a=%0h", m, a), 128'(r), 128'(2'd3));
        chk($sformatf("rnd_err_lat m%0d", m), 128'(c), 128'(1));
        chk($sformatf("rnd_err_data m%0d", m), 128'(rdv), 128'(0));
      end else begin
        chk($sformatf("rnd_resp m%0d a=%0h", m, a), 128'(r), 128'(2'd1));
        chk($sformatf("rnd_data m%0d a=%0h", m, a), 128'(rdv), 128'(expd));
        if (cmd == 3'd1) ref_mem[a] = d;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [2:0]  icmd;
    logic [31:0] iaddr;
    logic [2:0]  dcmd;
    logic [31:0] daddr;
    logic [4:0]  sacc;
    logic        iacc;
    logic        dacc;
    logic [9:0]  own;   // 2 bits per port: 0 none, 1 I, 2 D
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic [1:0] r; logic [DW-1:0] d; int c; int bad;
    logic [70:0] ib, db, eb;
    logic [1:0] o;

    tbl[0]  = '{3'd1, 32'h0000_0004, 3'd0, 32'h0000_0000, 5'h1f, 1'b1, 1'b0, 10'h001};
    tbl[1]  = '{3'd0, 32'h0000_0000, 3'd2, 32'h0000_0008, 5'h00, 1'b0, 1'b0, 10'h002};
    tbl[2]  = '{3'd2, 32'h0000_0004, 3'd2, 32'h0000_0008, 5'h1f, 1'b0, 1'b1, 10'h002};
    tbl[3]  = '{3'd2, 32'h8020_0004, 3'd2, 32'h8030_0008, 5'h1f, 1'b1, 1'b1, 10'h240};
    tbl[4]  = '{3'd3, 32'h0000_0004, 3'd1, 32'h8000_0000, 5'h1f, 1'b0, 1'b1, 10'h008};
    tbl[5]  = '{3'd2, 32'h9000_0000, 3'd0, 32'h0000_0000, 5'h00, 1'b1, 1'b0, 10'h000};
    tbl[6]  = '{3'd7, 32'h8000_0000, 3'd4, 32'h0000_0000, 5'h1f, 1'b0, 1'b0, 10'h000};
    tbl[7]  = '{3'd1, 32'h8010_0000, 3'd1, 32'h8000_0000, 5'h00, 1'b0, 1'b0, 10'h018};
    tbl[8]  = '{3'd1, 32'h8000_0000, 3'd1, 32'h8000_0000, 5'h1f, 1'b0, 1'b1, 10'h008};
    tbl[9]  = '{3'd2, 32'h7FFF_FFFC, 3'd1, 32'h8040_0000, 5'h1f, 1'b1, 1'b1, 10'h001};
    tbl[10] = '{3'd1, 32'h8030_0000, 3'd2, 32'h0000_0000, 5'h0f, 1'b0, 1'b1, 10'h102};

    for (int m = 0; m < 2; m++) begin
      maddr[m] = '0; mcmd[m] = 3'd0; mdata[m] = '0; mben[m] = '0;
    end

    // Outputs stay quiet while reset is held, even with a live request.
    @(negedge clk);
    maddr[0] = 32'h4; mcmd[0] = 3'd1; mdata[0] = 32'hDEAD_BEEF; mben[0] = 4'hF; man_acc = 5'h1f;
    #1;
    chk("rst_I_acc", 128'(macc[0]), 128'(0));
    chk("rst_P0_cmd", 128'({pcmd[0], paddr[0]}), 128'(0));
    mcmd[0] = 3'd0; maddr[0] = '0; mdata[0] = '0; mben[0] = '0; man_acc = '0;
    @(posedge clk); #1 nrst = 1'b0;

    // Combinational routing/accept table, applied and withdrawn within one cycle.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      maddr[0] = tbl[i].iaddr; mcmd[0] = tbl[i].icmd; mdata[0] = ~tbl[i].iaddr; mben[0] = 4'hC;
      maddr[1] = tbl[i].daddr; mcmd[1] = tbl[i].dcmd;
      mdata[1] = tbl[i].daddr ^ 32'h1234_5678; mben[1] = 4'h3;
      man_acc = tbl[i].sacc;
      #1;
      chk($sformatf("tbl%0d_I_acc", i), 128'(macc[0]), 128'(tbl[i].iacc));
      chk($sformatf("tbl%0d_D_acc", i), 128'(macc[1]), 128'(tbl[i].dacc));
      ib = {tbl[i].icmd, tbl[i].iaddr, ~tbl[i].iaddr, 4'hC};
      db = {tbl[i].dcmd, tbl[i].daddr, tbl[i].daddr ^ 32'h1234_5678, 4'h3};
      for (int n = 0; n < 5; n++) begin
        o  = tbl[i].own[2*n +: 2];
        eb = (o == 2'd1) ? ib : (o == 2'd2) ? db : '0;
        chk($sformatf("tbl%0d_P%0d", i, n), 128'({pcmd[n], paddr[n], pdata[n], pben[n]}), 128'(eb));
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        maddr[m] = '0; mcmd[m] = 3'd0; mdata[m] = '0; mben[m] = '0;
      end
      man_acc = '0;
    end

    // Directed: writes, then conflicts under known round-robin history.
    @(posedge clk); #1;
    man_mode = 1'b0; rnd_acc = 1'b0; lat_min = 0; lat_max = 2;
    do_txn(0, 3'd1, 32'h4, 32'hF1F2F3F4, r, d, c);
    chk("wr_I_resp", 128'(r), 128'(2'd1));
    do_txn(1, 3'd1, 32'h8, 32'hF5F6F7F8, r, d, c);
    chk("wr_D_resp", 128'(r), 128'(2'd1));
    do_txn(0, 3'd2, 32'h4, '0, r, d, c);
    chk("rd_I_solo", 128'(d), 128'(32'hF1F2F3F4));
    conflict("conf1", 1'b1);
    do_txn(0, 3'd2, 32'h4, '0, r, d, c);
    conflict("conf2", 1'b1);
    do_txn(1, 3'd2, 32'h8, '0, r, d, c);
    chk("rd_D_solo", 128'(d), 128'(32'hF5F6F7F8));
    conflict("conf3", 1'b0);

    // Unmapped access: ERR, zero data, exactly one cycle after accept, for one cycle only.
    do_txn(1, 3'd2, 32'h9000_0000, '0, r, d, c);
    chk("unmapped_resp", 128'(r), 128'(2'd3));
    chk("unmapped_data", 128'(d), 128'(0));
    chk("unmapped_lat", 128'(c), 128'(1));
    @(negedge clk);
    chk("unmapped_pulse", 128'(msresp[1]), 128'(0));
    @(posedge clk); #1;
    do_txn(1, 3'd1, 32'h8010_0000, 32'h1, r, d, c);
    chk("simctl_wr_resp", 128'(r), 128'(2'd1));

    // Reset during an accepted transaction drops it; the late slave answer is ignored.
    lat_min = 4; lat_max = 4;
    maddr[0] = 32'h4; mcmd[0] = 3'd2; mben[0] = 4'hF;
    @(negedge clk);
    chk("rstdrop_acc", 128'(macc[0]), 128'(1));
    @(posedge clk); #1;
    mcmd[0] = 3'd0; maddr[0] = '0; mben[0] = '0;
    nrst = 1'b1;
    @(posedge clk); #1 nrst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (msresp[0] != 2'd0) bad++;
    end
    chk("rstdrop_no_resp", 128'(bad), 128'(0));

    // Random traffic from both masters with the monitor checking every port each cycle.
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1 nrst = 1'b0;
    lat_min = 0; lat_max = 2; rnd_acc = 1'b1; mon_en = 1'b1;
    fork
      master_run(0, 150);
      master_run(1, 150);
    join
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
